// File: rtl/pipe_ctrl_if.sv
// Execute-stage request / pipeline control bundle for pipe_ctrl.
// The master side raises the requests, and the slave side (the controller) drives the control outputs.
interface pipe_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              jump_en_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic              hold_req_i;
    logic              halt_req_i;
    logic              resume_i;
    logic              jump_en_o;
    logic [ADDR_W-1:0] jump_addr_o;
    logic              flush_o;
    logic              stall_pc_o;
    logic              stall_if_id_o;
    logic              stall_id_ex_o;
    logic              halted_o;
    logic              hold_timeout_o;

    modport master (
        output jump_en_i, jump_addr_i, hold_req_i, halt_req_i, resume_i,
        input  jump_en_o, jump_addr_o, flush_o, stall_pc_o, stall_if_id_o,
               stall_id_ex_o, halted_o, hold_timeout_o
    );

    modport slave (
        input  jump_en_i, jump_addr_i, hold_req_i, halt_req_i, resume_i,
        output jump_en_o, jump_addr_o, flush_o, stall_pc_o, stall_if_id_o,
               stall_id_ex_o, halted_o, hold_timeout_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: jump redirect with flush bubbles, hold stalls,
// hold watchdog and debug halt/resume.
module pipe_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int HOLD_MAX     = 16
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.slave    bus
);
    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam int HC_W = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d, hold_cnt_inc_s;
    logic              hold_timeout_q, hold_timeout_d;
    logic              jump_en_s, flush_s, stall_s, halted_s;
    logic [ADDR_W-1:0] jump_addr_s;

    // State, counters and sticky watchdog flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            flush_cnt_q    <= {FC_W{1'b0}};
            hold_cnt_q     <= {HC_W{1'b0}};
            hold_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            hold_timeout_q <= hold_timeout_d;
        end
    end

    // Hold counter saturates at HOLD_MAX instead of wrapping
    always_comb begin
        if (hold_cnt_q == HC_W'(HOLD_MAX)) begin
            hold_cnt_inc_s = hold_cnt_q;
        end else begin
            hold_cnt_inc_s = hold_cnt_q + HC_W'(1);
        end
    end

    // Next-state and control outputs; priority is halt > jump > hold
    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        hold_cnt_d     = hold_cnt_q;
        hold_timeout_d = hold_timeout_q;
        jump_en_s      = 1'b0;
        jump_addr_s    = {ADDR_W{1'b0}};
        flush_s        = 1'b0;
        stall_s        = 1'b0;
        halted_s       = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.halt_req_i) begin
                    state_d = ST_HALT;
                end else if (bus.jump_en_i) begin
                    jump_en_s   = 1'b1;
                    jump_addr_s = bus.jump_addr_i;
                    flush_s     = 1'b1;
                    if (FLUSH_CYCLES == 1) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
                    end
                end else if (bus.hold_req_i) begin
                    stall_s    = 1'b1;
                    state_d    = ST_HOLD;
                    hold_cnt_d = HC_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // Requests seen here come from wrong-path slots being flushed
                flush_s = 1'b1;
                if (bus.halt_req_i) begin
                    state_d     = ST_HALT;
                    flush_cnt_d = {FC_W{1'b0}};
                end else if (flush_cnt_q <= FC_W'(1)) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = {FC_W{1'b0}};
                end else begin
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
                end
            end
            ST_HOLD: begin
                stall_s = bus.hold_req_i;
                if (bus.halt_req_i) begin
                    state_d = ST_HALT;
                end else if (!bus.hold_req_i) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = {HC_W{1'b0}};
                end else if (hold_cnt_q >= HC_W'(HOLD_MAX - 1)) begin
                    state_d        = ST_HALT;
                    hold_cnt_d     = hold_cnt_inc_s;
                    hold_timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_inc_s;
                end
            end
            ST_HALT: begin
                halted_s = 1'b1;
                stall_s  = 1'b1;
                if (bus.resume_i && !bus.halt_req_i) begin
                    state_d     = ST_RUN;
                    hold_cnt_d  = {HC_W{1'b0}};
                    flush_cnt_d = {FC_W{1'b0}};
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Mealy outputs would follow the inputs in reset, so force them quiet while rst is high
    always_comb begin
        if (rst) begin
            bus.jump_en_o     = 1'b0;
            bus.jump_addr_o   = {ADDR_W{1'b0}};
            bus.flush_o       = 1'b0;
            bus.stall_pc_o    = 1'b0;
            bus.stall_if_id_o = 1'b0;
            bus.stall_id_ex_o = 1'b0;
            bus.halted_o      = 1'b0;
        end else begin
            bus.jump_en_o     = jump_en_s;
            bus.jump_addr_o   = jump_addr_s;
            bus.flush_o       = flush_s;
            bus.stall_pc_o    = stall_s;
            bus.stall_if_id_o = stall_s;
            bus.stall_id_ex_o = stall_s;
            bus.halted_o      = halted_s;
        end
    end

    assign bus.hold_timeout_o = hold_timeout_q;
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller between the execute stage and the fetch/decode pipeline registers. It turns the execute stage's jump and hold requests into the PC redirect plus per-stage flush and stall controls. It inserts a fixed number of flush bubbles after a taken jump and stalls the front end while a multi-cycle unit is busy. A hold watchdog and a debug halt/resume state machine complete the block.

Parameters:
ADDR_W, 32, width of jump target address
FLUSH_CYCLES, 2, cycles flush_o stays asserted per taken jump (>=1)
HOLD_MAX, 16, consecutive HOLD cycles before watchdog trip (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
jump_en_i  in  1  taken jump/branch from execute stage
jump_addr_i  in  ADDR_W  jump target from execute stage
hold_req_i  in  1  execute-stage hold (multi-cycle op busy)
halt_req_i  in  1  debug/ebreak halt request
resume_i  in  1  leave halt
jump_en_o  out  1  PC redirect enable
jump_addr_o  out  ADDR_W  PC redirect target, 0 when jump_en_o=0
flush_o  out  1  clear IF/ID and ID/EX to NOP
stall_pc_o  out  1  freeze PC
stall_if_id_o  out  1  freeze IF/ID register
stall_id_ex_o  out  1  freeze ID/EX register
halted_o  out  1  FSM in HALT
hold_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset: async on rst rising; while rst=1 every output is 0. state=RUN, flush_cnt=0, hold_cnt=0, hold_timeout_o=0.
- States: RUN, FLUSH, HOLD, HALT. Outputs are Mealy in RUN and HOLD, Moore in FLUSH and HALT.
- Priority within a cycle: halt_req_i > jump_en_i > hold_req_i.
- RUN:
  - halt_req_i=1: all outputs 0 this cycle; next state HALT.
  - Else jump_en_i=1: jump_en_o=1, jump_addr_o=jump_addr_i, flush_o=1, stalls 0, all same cycle (0 latency).
    - If FLUSH_CYCLES=1: stay RUN.
    - Else: next state FLUSH, flush_cnt=FLUSH_CYCLES-1.
    - hold_req_i is ignored in this cycle.
  - Else hold_req_i=1: stall_pc_o, stall_if_id_o and stall_id_ex_o =1 same cycle; next state HOLD; hold_cnt=1.
  - Else: all outputs 0.
- FLUSH:
  - flush_o=1; jump_en_o=0; stalls 0.
  - jump_en_i and hold_req_i are ignored, since they come from flushed wrong-path slots.
  - flush_cnt decrements each cycle; when flush_cnt=1, next state RUN.
  - halt_req_i=1: next state HALT, abandoning the remaining bubbles.
- HOLD:
  - All three stalls = hold_req_i, combinational; flush_o=0; jump_en_i is ignored.
  - hold_req_i=0: stalls drop the same cycle; next state RUN; hold_cnt cleared.
  - hold_req_i=1: hold_cnt increments.
    - If hold_cnt reaches HOLD_MAX-1 while the request is still asserted, hold_timeout_o is set next edge and the next state is HALT.
    - hold_timeout_o stays 1 until reset.
  - halt_req_i=1: next state HALT.
- HALT:
  - halted_o=1; all three stalls =1; flush_o=0, jump_en_o=0.
  - resume_i=1 and halt_req_i=0: next state RUN, with hold_cnt and flush_cnt cleared.
  - resume_i and halt_req_i both 1: stay in HALT.
  - resume_i is ignored in all other states.
- Counters:
  - flush_cnt is ceil(log2(FLUSH_CYCLES+1)) bits.
  - hold_cnt is ceil(log2(HOLD_MAX+1)) bits and saturates; it never wraps.
- Mid-operation reset from any state returns to RUN with all outputs 0 immediately (asynchronous), and clears the sticky flag.
- No output is X in any state; unused encodings fall to RUN.

Test Plan:
- Reset then idle: rst pulse mid-HOLD -> all outputs 0 immediately; after release, hold_req_i=0 keeps all outputs 0 and state RUN.
- Taken jump: jump_en_i=1, jump_addr_i=32'h8000_0010 for one cycle, FLUSH_CYCLES=2 -> jump_en_o=1 with addr 32'h8000_0010 in cycle 0; flush_o=1 in cycles 0 and 1 and 0 in cycle 2. A jump_en_i=1 injected in cycle 1 produces no redirect.
- Hold: hold_req_i=1 for 5 cycles -> all stalls =1 for exactly those 5 cycles, deasserting the same cycle hold drops; hold_timeout_o stays 0.
- Simultaneous events: jump_en_i=1 and hold_req_i=1 in RUN -> redirect and flush only, stalls 0; halt_req_i=1 together with jump_en_i -> no redirect, and halted_o=1 the next cycle.
- Watchdog: hold_req_i held 20 cycles with HOLD_MAX=16 -> hold_timeout_o=1 and halted_o=1 after the 16th hold cycle. Stalls stay 1 while halted; resume_i=1 (hold_req_i=0) returns to RUN with outputs 0 and hold_timeout_o still 1.
- Halt/resume: halt_req_i pulse -> halted_o=1 and all stalls 1 from the next cycle. resume_i together with halt_req_i -> remains halted. resume_i alone -> RUN the next cycle.
